load_store_unit: RTL

- Sits directly upstream of memory_unit; the RISC-V execute stage issues RV32I loads and stores through it.
- Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide memory_unit read/write cycles.
- memory_unit has no byte enables, so sub-word stores use read-modify-write.
- Performs load byte-lane extraction with sign/zero extension and flags misaligned or illegal accesses.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide memory_unit without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
//
// state  | meaning
// IDLE   | ready for a request
// RD     | mem_rden pulse for a load or sub-word store
// RDWAIT | mem_q valid; register load result or merged store word
// WR     | mem_wren pulse with full or merged word
// RESP   | one-cycle resp_valid
module load_store_unit #(
   parameter int ADDRSIZE = 16,
   parameter int WORDSIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDRSIZE+1:0]   req_addr,
   input  logic [WORDSIZE-1:0]   req_wdata,
   output logic                  resp_valid,
   output logic [WORDSIZE-1:0]   resp_rdata,
   output logic                  resp_err,
   output logic                  mem_wren,
   output logic                  mem_rden,
   output logic [ADDRSIZE-1:0]   mem_addr,
   output logic [WORDSIZE-1:0]   mem_d,
   input  logic [WORDSIZE-1:0]   mem_q
);

   typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            boff_q, boff_d;
   logic [WORDSIZE-1:0]   wdata_q, wdata_d;
   logic [ADDRSIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [WORDSIZE-1:0]   mem_d_q, mem_d_d;
   logic [WORDSIZE-1:0]   rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  req_err;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [WORDSIZE-1:0]   load_ext;
   logic [WORDSIZE-1:0]   merged;

   always_comb begin
      req_err = 1'b0;
      if (req_we) begin
         if (!(req_funct3 inside {3'b000, 3'b001, 3'b010})) req_err = 1'b1;
      end else begin
         if (!(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
      end
      if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
   end

   always_comb begin
      lane_b = mem_q[7:0];
      case (boff_q)
         2'd1:    lane_b = mem_q[15:8];
         2'd2:    lane_b = mem_q[23:16];
         2'd3:    lane_b = mem_q[31:24];
         default: lane_b = mem_q[7:0];
      endcase
      lane_h = boff_q[1] ? mem_q[31:16] : mem_q[15:0];

      case (f3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = mem_q;
      endcase

      // Bytes outside the stored lane(s) are preserved from the word just read.
      case (f3_q[1:0])
         2'b00: begin
            case (boff_q)
               2'd0:    merged = {mem_q[31:8], wdata_q[7:0]};
               2'd1:    merged = {mem_q[31:16], wdata_q[7:0], mem_q[7:0]};
               2'd2:    merged = {mem_q[31:24], wdata_q[7:0], mem_q[15:0]};
               default: merged = {wdata_q[7:0], mem_q[23:0]};
            endcase
         end
         2'b01:   merged = boff_q[1] ? {wdata_q[15:0], mem_q[15:0]} : {mem_q[31:16], wdata_q[15:0]};
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      f3_d       = f3_q;
      boff_d     = boff_q;
      wdata_d    = wdata_q;
      mem_addr_d = mem_addr_q;
      mem_d_d    = mem_d_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               boff_d  = req_addr[1:0];
               wdata_d = req_wdata;
               if (req_err) begin
                  state_d = RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (req_we && req_funct3[1:0] == 2'b10) begin
                  state_d    = WR;
                  mem_addr_d = req_addr[ADDRSIZE+1:2];
                  mem_d_d    = req_wdata;
               end else begin
                  state_d    = RD;
                  mem_addr_d = req_addr[ADDRSIZE+1:2];
               end
            end
         end
         RD:     state_d = RDWAIT;
         RDWAIT: begin
            if (we_q) begin
               state_d = WR;
               mem_d_d = merged;
            end else begin
               state_d = RESP;
               rdata_d = load_ext;
               err_d   = 1'b0;
            end
         end
         WR: begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         boff_q     <= 2'd0;
         wdata_q    <= '0;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         boff_q     <= boff_d;
         wdata_q    <= wdata_d;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign req_ready  = (state_q == IDLE);
   assign mem_rden   = (state_q == RD);
   assign mem_wren   = (state_q == WR);
   assign resp_valid = (state_q == RESP);
   assign mem_addr   = mem_addr_q;
   assign mem_d      = mem_d_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
